// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory access arbiter.
//   state_e   : arbiter mode (FUNC, DRAIN, TEST)
//   owner_e   : read-return owner tag carried through the tag pipeline
//   TAG_DEPTH : number of read-tag stages between acceptance and data return
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        FUNC  = 2'd0,
        DRAIN = 2'd1,
        TEST  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_BIST = 1'b0,
        OWN_USR  = 1'b1
    } owner_e;

    localparam int TAG_DEPTH = 2;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner selection for the memory access arbiter.
// Ports:
//   clk, rst            : clock / async active-low reset (round-robin build only)
//   state, test_mode    : current arbiter mode and requested mode
//   bist_req, usr_req   : command requests
//   bist_gnt, usr_gnt   : grants, at most one high per cycle
// Macro MEM_ARB_ROUND_ROBIN_EN: defined -> alternating priority with a pointer
// register; undefined -> fixed priority, MBIST wins.
module mem_arb_sel
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic   clk,
    input  logic   rst,
`endif
    input  state_e state,
    input  logic   test_mode,
    input  logic   bist_req,
    input  logic   usr_req,
    output logic   bist_gnt,
    output logic   usr_gnt
);

    // Functional arbitration only while in FUNC and no mode change is pending.
    logic func_arb;
    assign func_arb = (state == FUNC) && !test_mode;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // ptr_q names the requester that wins the next contested cycle.
    owner_e ptr_q;
    owner_e ptr_d;

    always_comb begin
        bist_gnt = 1'b0;
        usr_gnt  = 1'b0;
        ptr_d    = ptr_q;
        if (func_arb) begin
            if (bist_req && usr_req) begin
                if (ptr_q == OWN_USR) begin
                    usr_gnt = 1'b1;
                end else begin
                    bist_gnt = 1'b1;
                end
            end else begin
                bist_gnt = bist_req;
                usr_gnt  = usr_req;
            end
            // Any grant hands priority to the other requester.
            if (usr_gnt) begin
                ptr_d = OWN_BIST;
            end else if (bist_gnt) begin
                ptr_d = OWN_USR;
            end
        end else if ((state == TEST) && test_mode) begin
            bist_gnt = bist_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= OWN_USR;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        bist_gnt = 1'b0;
        usr_gnt  = 1'b0;
        if (func_arb) begin
            bist_gnt = bist_req;
            usr_gnt  = usr_req && !bist_req;
        end else if ((state == TEST) && test_mode) begin
            bist_gnt = bist_req;
        end
    end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory between the MBIST engine and a functional
// user port. The winning command is registered onto mem_*; read data returns
// two cycles after the grant to the owner recorded in a two-stage tag pipeline.
// A mode FSM (FUNC / DRAIN / TEST) drains outstanding reads before switching.
// Ports:
//   clk, rst (async active-low), test_mode
//   bist_* / usr_*  : req/gnt command ports and rvalid/rdata returns
//   mem_*           : registered memory command, mem_rdata return
//   in_test         : high while in TEST
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test_mode,
    input  logic                  bist_req,
    input  logic                  bist_we,
    input  logic [ADDR_WIDTH-1:0] bist_addr,
    input  logic [DATA_WIDTH-1:0] bist_wdata,
    output logic                  bist_gnt,
    output logic                  bist_rvalid,
    output logic [DATA_WIDTH-1:0] bist_rdata,
    input  logic                  usr_req,
    input  logic                  usr_we,
    input  logic [ADDR_WIDTH-1:0] usr_addr,
    input  logic [DATA_WIDTH-1:0] usr_wdata,
    output logic                  usr_gnt,
    output logic                  usr_rvalid,
    output logic [DATA_WIDTH-1:0] usr_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  in_test
);

    state_e                state_q, state_d;
    logic                  in_test_q, in_test_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [TAG_DEPTH-1:0]  tag_vld_q, tag_vld_d;
    logic [TAG_DEPTH-1:0]  tag_own_q, tag_own_d;
    logic [DATA_WIDTH-1:0] bist_rdata_q, bist_rdata_d;
    logic [DATA_WIDTH-1:0] usr_rdata_q, usr_rdata_d;

    logic bist_acc;
    logic usr_acc;

    mem_arb_sel u_sel (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .state     (state_q),
        .test_mode (test_mode),
        .bist_req  (bist_req),
        .usr_req   (usr_req),
        .bist_gnt  (bist_gnt),
        .usr_gnt   (usr_gnt)
    );

    assign bist_acc = bist_req && bist_gnt;
    assign usr_acc  = usr_req && usr_gnt;

    // The last tag stage lines up with mem_rdata from the memory.
    assign bist_rvalid = tag_vld_q[TAG_DEPTH-1] && (tag_own_q[TAG_DEPTH-1] == OWN_BIST);
    assign usr_rvalid  = tag_vld_q[TAG_DEPTH-1] && (tag_own_q[TAG_DEPTH-1] == OWN_USR);

    always_comb begin
        // Mode FSM; DRAIN leaves only once no read is in flight.
        state_d = state_q;
        unique case (state_q)
            FUNC:    if (test_mode)  state_d = DRAIN;
            TEST:    if (!test_mode) state_d = DRAIN;
            DRAIN:   if (tag_vld_q == '0) state_d = test_mode ? TEST : FUNC;
            default: state_d = FUNC;
        endcase
        in_test_d = (state_d == TEST);

        // Command register: hold address/data when nothing is accepted.
        mem_en_d    = bist_acc || usr_acc;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (bist_acc) begin
            mem_we_d    = bist_we;
            mem_addr_d  = bist_addr;
            mem_wdata_d = bist_wdata;
        end else if (usr_acc) begin
            mem_we_d    = usr_we;
            mem_addr_d  = usr_addr;
            mem_wdata_d = usr_wdata;
        end

        // Tag pipeline: only reads are tracked.
        tag_vld_d = {tag_vld_q[TAG_DEPTH-2:0], (bist_acc && !bist_we) || (usr_acc && !usr_we)};
        tag_own_d = {tag_own_q[TAG_DEPTH-2:0], usr_acc ? OWN_USR : OWN_BIST};

        // Return data passes through on rvalid and otherwise holds.
        bist_rdata_d = bist_rvalid ? mem_rdata : bist_rdata_q;
        usr_rdata_d  = usr_rvalid  ? mem_rdata : usr_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FUNC;
            in_test_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
            bist_rdata_q <= '0;
            usr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            in_test_q    <= in_test_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
            bist_rdata_q <= bist_rdata_d;
            usr_rdata_q  <= usr_rdata_d;
        end
    end

    assign in_test    = in_test_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign bist_rdata = bist_rdata_d;
    assign usr_rdata  = usr_rdata_d;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       test_mode;
    logic       bist_req, bist_we;
    logic [7:0] bist_addr, bist_wdata;
    logic       bist_gnt, bist_rvalid;
    logic [7:0] bist_rdata;
    logic       usr_req, usr_we;
    logic [7:0] usr_addr, usr_wdata;
    logic       usr_gnt, usr_rvalid;
    logic [7:0] usr_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       in_test;

    mem_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .test_mode(test_mode),
        .bist_req(bist_req), .bist_we(bist_we), .bist_addr(bist_addr),
        .bist_wdata(bist_wdata), .bist_gnt(bist_gnt), .bist_rvalid(bist_rvalid),
        .bist_rdata(bist_rdata),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid),
        .usr_rdata(usr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .in_test(in_test)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data one cycle after mem_en.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        else pass_cnt++;
    endtask

    typedef struct {
        logic       own;   // 1 = user, 0 = BIST
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t sb_q[$];

    task automatic push(input logic own, input logic [7:0] d);
        exp_t e;
        e.own = own; e.data = d; e.due = cyc_cnt + 2;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per read return.
    exp_t       m_e;
    logic [7:0] last_usr = 8'h00;
    logic [7:0] last_bist = 8'h00;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            last_usr  = 8'h00;
            last_bist = 8'h00;
        end
        if (bist_rvalid || usr_rvalid) begin
            if (bist_rvalid && usr_rvalid) check("rvalid_both", 1, 0);
            if (sb_q.size() == 0) begin
                check("rvalid_unexpected", 1, 0);
            end else begin
                m_e = sb_q.pop_front();
                check("rv_cycle", cyc_cnt, m_e.due);
                if (m_e.own) begin
                    check("usr_rvalid", usr_rvalid, 1);
                    check("usr_rdata", usr_rdata, m_e.data);
                    check("bist_rdata_hold", bist_rdata, last_bist);
                    last_usr = usr_rdata;
                end else begin
                    check("bist_rvalid", bist_rvalid, 1);
                    check("bist_rdata", bist_rdata, m_e.data);
                    check("usr_rdata_hold", usr_rdata, last_usr);
                    last_bist = bist_rdata;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_usr(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        usr_req = r; usr_we = w; usr_addr = a; usr_wdata = d;
    endtask

    task automatic set_bist(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bist_req = r; bist_we = w; bist_addr = a; bist_wdata = d;
    endtask

    task automatic check_gnt(input string n, input logic eb, input logic eu);
        check({n, "_bist_gnt"}, bist_gnt, eb);
        check({n, "_usr_gnt"}, usr_gnt, eu);
    endtask

    task automatic check_all_zero(input string n);
        check({n, "_gnt"},     {bist_gnt, usr_gnt}, 0);
        check({n, "_rvalid"},  {bist_rvalid, usr_rvalid}, 0);
        check({n, "_mem_ctl"}, {mem_en, mem_we}, 0);
        check({n, "_mem_addr"}, mem_addr, 0);
        check({n, "_mem_wdata"}, mem_wdata, 0);
        check({n, "_rdata"},   {bist_rdata, usr_rdata}, 0);
        check({n, "_in_test"}, in_test, 0);
    endtask

    logic [4:0] win;  // per cycle of the contention test: 1 = user wins

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = 5'b10101;
`else
        win = 5'b10000;
`endif
        rst = 1'b0; test_mode = 1'b0;
        set_usr(0, 0, 8'h00, 8'h00);
        set_bist(0, 0, 8'h00, 8'h00);
        tick(); tick(); #1;
        check_all_zero("reset");
        rst = 1'b1;
        tick(); #1;
        check_all_zero("idle");

        // Contention: both request writes for five cycles (BIST drops after four)
        for (int i = 0; i < 5; i++) begin
            tick();
            set_usr(1, 1, 8'h01, 8'h11);
            set_bist(i < 4, 1, 8'h02, 8'h22);
            #1;
            check_gnt("contend", !win[i], win[i]);
            if (i > 0) begin
                check("contend_mem_addr", mem_addr, win[i-1] ? 8'h01 : 8'h02);
                check("contend_mem_en", mem_en, 1);
            end
        end
        tick(); set_usr(0, 0, 8'h00, 8'h00); set_bist(0, 0, 8'h00, 8'h00); #1;
        check("contend_last_addr", mem_addr, 8'h01);
        check("contend_last_wdata", mem_wdata, 8'h11);

        // User write 0x10 <- 0xA5, then read it back
        tick(); set_usr(1, 1, 8'h10, 8'hA5); #1;
        check_gnt("wr", 0, 1);
        tick(); set_usr(1, 0, 8'h10, 8'h00); #1;
        check_gnt("rd", 0, 1);
        check("wr_mem_ctl", {mem_en, mem_we}, 2'b11);
        check("wr_mem_addr", mem_addr, 8'h10);
        check("wr_mem_wdata", mem_wdata, 8'hA5);
        push(1, 8'hA5);
        tick(); set_usr(0, 0, 8'h00, 8'h00); #1;
        check("rd_mem_ctl", {mem_en, mem_we}, 2'b10);
        check("rd_mem_addr", mem_addr, 8'h10);
        tick(); #1;
        check("idle_mem_en", mem_en, 0);
        check("idle_addr_hold", mem_addr, 8'h10);

        // Pipelined reads: user 0x01, BIST 0x02, user 0x10
        tick(); set_usr(1, 0, 8'h01, 8'h00); #1;
        check_gnt("pipe0", 0, 1); push(1, 8'h11);
        tick(); set_usr(0, 0, 8'h00, 8'h00); set_bist(1, 0, 8'h02, 8'h00); #1;
        check_gnt("pipe1", 1, 0); push(0, 8'h22);
        tick(); set_bist(0, 0, 8'h00, 8'h00); set_usr(1, 0, 8'h10, 8'h00); #1;
        check_gnt("pipe2", 0, 1); push(1, 8'hA5);
        tick(); set_usr(0, 0, 8'h00, 8'h00);
        tick(); tick(); tick(); #1;

        // Enter TEST one cycle after a user read grant
        tick(); set_usr(1, 0, 8'h10, 8'h00); #1;
        check_gnt("pre_tm", 0, 1); push(1, 8'hA5);
        tick(); set_usr(0, 0, 8'h00, 8'h00); set_bist(1, 0, 8'h02, 8'h00); test_mode = 1'b1; #1;
        check_gnt("tm_func", 0, 0);
        tick(); #1;
        check_gnt("drain_a", 0, 0); check("drain_a_in_test", in_test, 0);
        tick(); #1;
        check_gnt("drain_b", 0, 0); check("drain_b_in_test", in_test, 0);
        tick(); #1;
        check("test_in_test", in_test, 1);
        check_gnt("test_bist", 1, 0); push(0, 8'h22);
        tick(); set_bist(0, 0, 8'h00, 8'h00); set_usr(1, 0, 8'h10, 8'h00); #1;
        check_gnt("test_usr_a", 0, 0);
        tick(); #1;
        check_gnt("test_usr_b", 0, 0); check("test_b_in_test", in_test, 1);
        tick(); test_mode = 1'b0; #1;
        check_gnt("test_exit", 0, 0);
        tick(); #1;
        check_gnt("drain_back", 0, 0); check("drain_back_in_test", in_test, 0);
        tick(); #1;
        check_gnt("func_back", 0, 1); push(1, 8'hA5);
        tick(); set_usr(0, 0, 8'h00, 8'h00); #1;

        // test_mode pulse that falls during DRAIN returns to FUNC
        tick(); set_usr(1, 0, 8'h01, 8'h00); #1;
        check_gnt("pulse_rd", 0, 1); push(1, 8'h11);
        tick(); set_usr(0, 0, 8'h00, 8'h00); test_mode = 1'b1; #1;
        check("pulse_b_in_test", in_test, 0);
        tick(); set_usr(1, 1, 8'h60, 8'h3C); #1;
        check_gnt("pulse_drain_a", 0, 0); check("pulse_drain_a_in_test", in_test, 0);
        tick(); test_mode = 1'b0; #1;
        check_gnt("pulse_drain_b", 0, 0); check("pulse_drain_b_in_test", in_test, 0);
        tick(); #1;
        check_gnt("pulse_func", 0, 1); check("pulse_func_in_test", in_test, 0);
        tick(); set_usr(0, 0, 8'h00, 8'h00); #1;
        check("pulse_end_in_test", in_test, 0);

        // Reset the cycle after a read grant: the read never returns
        tick(); set_usr(1, 0, 8'h20, 8'h00); #1;
        check_gnt("rst_rd", 0, 1);
        tick(); set_usr(0, 0, 8'h00, 8'h00); #1;
        check("rst_pre_mem_en", mem_en, 1);
        rst = 1'b0; #1;
        check_all_zero("async_rst");
        tick(); tick(); rst = 1'b1;
        tick(); tick(); tick(); #1;
        check("post_rst_mem_en", mem_en, 0);
        check("post_rst_rvalid", {bist_rvalid, usr_rvalid}, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
